aes_key_expand: RTL and testbench

AES_KEY_EXPAND -- requirements
Module: aes_key_expand

---
 rtl/aes_pkg.sv | 46 ++++
 rtl/aes_key_expand_sbox.sv | 44 ++++
 rtl/aes_key_expand.sv | 179 +++++++++++++++++
 tb/tb_aes_key_expand.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES key expansion block.
// AES-192/256 support is enabled with AES_KEYEXP_256_EN.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXPAND,
        DONE
    } state_t;

    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    localparam logic [7:0] RCON_INIT = 8'h01;

    function automatic logic [3:0] nk_of(input logic [1:0] s);
        logic [3:0] n;
        unique case (s)
            2'd0:    n = NK_128;
            2'd1:    n = NK_192;
            default: n = NK_256;
        endcase
        return n;
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] s);
        logic [3:0] n;
        unique case (s)
            2'd0:    n = NR_128;
            2'd1:    n = NR_192;
            default: n = NR_256;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expand_sbox.sv
// Combinational AES S-box: GF(2^8) inverse (a^254) then affine map.
// Used four times by aes_key_expand to form SubWord.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    function automatic logic [7:0] gmul(
        input logic [7:0] x,
        input logic [7:0] z
    );
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int b = 0; b < 8; b++) begin
            if (z[b]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // a^254 = a^2 * a^4 * ... * a^128; zero maps to zero
    always_comb begin
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        y = inv
          ^ {inv[6:0], inv[7]}
          ^ {inv[5:0], inv[7:6]}
          ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]}
          ^ 8'h63;
    end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES key schedule, one word per cycle, with round-key read port.
// Define AES_KEYEXP_256_EN to add AES-192/256 (60-word buffer).
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int KEY_W = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key,
    input  logic [1:0]       sel,
    output logic             busy,
    output logic             key_valid,
    input  logic [3:0]       rk_idx,
    output logic [127:0]     round_key
);

`ifdef AES_KEYEXP_256_EN
    localparam int NW    = 60;
    localparam int NKMAX = 8;
    localparam int KQ_W  = 256;
`else
    localparam int NW    = 44;
    localparam int NKMAX = 4;
    localparam int KQ_W  = 128;
`endif

    state_t state;
    state_t state_d;
    logic   accept;

    logic [KQ_W-1:0] key_q;
    logic [5:0]      idx;
    logic [2:0]      ph;
    logic [7:0]      rcon;
    logic [31:0]     w [NW];

    logic [3:0] nk;
    logic [3:0] nr;
    logic       is256;

`ifdef AES_KEYEXP_256_EN
    logic [1:0] sel_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q <= 2'd0;
        end else if (accept) begin
            sel_q <= sel;
        end
    end

    assign nk    = nk_of(sel_q);
    assign nr    = nr_of(sel_q);
    assign is256 = (nk == NK_256);
`else
    logic unused_in;

    assign unused_in = ^{key[KEY_W-129:0], sel};
    assign nk        = NK_128;
    assign nr        = NR_128;
    assign is256     = 1'b0;
`endif

    logic [5:0] last;
    logic       we;
    logic       kv_next;

    assign last      = {nr, 2'b11};
    assign we        = (state == EXPAND) && (idx <= last);
    assign busy      = (state == LOAD) || (state == EXPAND);
    assign key_valid = (state == DONE);
    assign kv_next   = (state_d == DONE);

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    accept  = 1'b1;
                end
            end
            LOAD:   state_d = EXPAND;
            EXPAND: begin
                if (idx > last) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Word generation datapath
    logic [31:0] prev;
    logic [31:0] back;
    logic [31:0] sin;
    logic [31:0] sub;
    logic [31:0] temp;
    logic [31:0] new_w;

    assign prev = w[idx - 6'd1];
    assign back = w[idx - {2'b00, nk}];
    assign sin  = (ph == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .a (sin[8*b +: 8]),
            .y (sub[8*b +: 8])
        );
    end

    always_comb begin
        temp = prev;
        if (ph == 3'd0) begin
            temp = sub ^ {rcon, 24'h0};
        end else if (is256 && ph == 3'd4) begin
            temp = sub;
        end
        new_w = back ^ temp;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            key_q <= '0;
            idx   <= 6'd0;
            ph    <= 3'd0;
            rcon  <= RCON_INIT;
        end else begin
            state <= state_d;
            if (accept) begin
                key_q <= key[KEY_W-1 -: KQ_W];
            end
            if (state == LOAD) begin
                idx  <= {2'b00, nk};
                ph   <= 3'd0;
                rcon <= RCON_INIT;
            end else if (we) begin
                idx <= idx + 6'd1;
                if ({1'b0, ph} == nk - 4'd1) begin
                    ph   <= 3'd0;
                    rcon <= xtime(rcon);
                end else begin
                    ph <= ph + 3'd1;
                end
            end
        end
    end

    // Schedule storage; contents only observable once key_valid is set
    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            for (int j = 0; j < NKMAX; j++) begin
                if (4'(j) < nk) w[6'(j)] <= key_q[KQ_W-1-32*j -: 32];
            end
        end else if (we) begin
            w[idx] <= new_w;
        end
    end

    logic [5:0] base;
    logic       rk_ok;

    assign base  = {rk_idx, 2'b00};
    assign rk_ok = (rk_idx <= nr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            round_key <= '0;
        end else if (kv_next && rk_ok) begin
            round_key <= {w[base], w[base + 6'd1],
                          w[base + 6'd2], w[base + 6'd3]};
        end else begin
            round_key <= '0;
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand against a FIPS-197 style model.
// Honors AES_KEYEXP_256_EN for the AES-192/256 cases.
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [255:0] key = '0;
    logic [1:0]   sel = 2'd0;
    logic         busy;
    logic         key_valid;
    logic [3:0]   rk_idx = 4'd0;
    logic [127:0] round_key;

    int total = 0;
    int bad   = 0;

    aes_key_expand #(.KEY_W(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key       (key),
        .sel       (sel),
        .busy      (busy),
        .key_valid (key_valid),
        .rk_idx    (rk_idx),
        .round_key (round_key)
    );

    always #5 clk = ~clk;

    bit [7:0]    sb [256];
    logic [31:0] mw [60];
    int          m_nr;

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h11b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] o;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                o[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                     ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            sb[x] = o;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    task automatic model(input logic [255:0] k, input logic [1:0] s);
        int nk;
        logic [31:0] t;
        logic [7:0] rc;
`ifdef AES_KEYEXP_256_EN
        nk = (s == 2'd0) ? 4 : (s == 2'd1) ? 6 : 8;
`else
        nk = (s == 2'd0) ? 4 : 4;
`endif
        m_nr = nk + 6;
        for (int i = 0; i < nk; i++) mw[i] = k[255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < 4 * (m_nr + 1); i++) begin
            t = mw[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            mw[i] = mw[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] exp_rk(input int r);
        if (r > m_nr) return 128'h0;
        return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [255:0] k, input logic [1:0] s,
                          input string tag);
        model(k, s);
        @(negedge clk);
        key   = k;
        sel   = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        key   = {$urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom};
        sel   = 2'($urandom);
        chk({tag, " busy_on"}, 128'(busy), 128'(1));
        chk({tag, " kv_drop"}, 128'(key_valid), 128'(0));
        chk({tag, " rk_drop"}, round_key, 128'h0);
    endtask

    task automatic wait_done(input string tag, input int elapsed);
        int cnt;
        int lat;
        cnt = elapsed;
        while (cnt < 200) begin
            @(posedge clk);
            cnt++;
            #1;
            if (key_valid) break;
        end
        lat = (m_nr == 10) ? 42 : (m_nr == 12) ? 48 : 54;
        chk({tag, " latency"}, 128'(cnt), 128'(lat));
        chk({tag, " busy_off"}, 128'(busy), 128'(0));
    endtask

    task automatic read_rk(input int r, input string tag);
        @(negedge clk);
        rk_idx = 4'(r);
        @(posedge clk);
        #1;
        chk($sformatf("%s rk%0d", tag, r), round_key, exp_rk(r));
    endtask

    task automatic read_all(input string tag);
        for (int r = 0; r < 16; r++) read_rk(r, tag);
    endtask

    localparam logic [127:0] K128A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K128B = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    initial begin
        logic [255:0] rk;
        logic [1:0]   rs;
        build_sbox();

        #12;
        chk("reset busy", 128'(busy), 128'(0));
        chk("reset kv", 128'(key_valid), 128'(0));
        chk("reset rk", round_key, 128'h0);
        @(negedge clk);
        rst = 1'b1;

        launch({K128A, 128'hdeadbeef_cafef00d_01234567_89abcdef}, 2'd0, "k128a");
        wait_done("k128a", 0);
        read_rk(10, "k128a");
        chk("k128a fips10", round_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        read_all("k128a");

        launch({K128B, 128'h0}, 2'd0, "k128b");
        wait_done("k128b", 0);
        read_rk(1, "k128b");
        chk("k128b fips1", round_key, 128'ha0fafe1788542cb123a339392a6c7605);
        read_rk(10, "k128b");
        chk("k128b fips10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

`ifdef AES_KEYEXP_256_EN
        launch({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
               2'd1, "k192");
        wait_done("k192", 0);
        read_rk(12, "k192");
        chk("k192 fips12", round_key, 128'ha4970a331a78dc09c418c271e3a41d5d);
        read_rk(13, "k192");
        chk("k192 past_nr", round_key, 128'h0);

        launch(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
               2'd2, "k256");
        wait_done("k256", 0);
        read_rk(14, "k256");
        chk("k256 fips14", round_key, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        read_rk(0, "k256");
        chk("k256 fips0", round_key, 128'h000102030405060708090a0b0c0d0e0f);
`endif

        launch({K128B, 128'h55aa55aa_55aa55aa_55aa55aa_55aa55aa}, 2'd2, "sel2");
        wait_done("sel2", 0);
        read_all("sel2");

        for (int n = 0; n < 6; n++) begin
            rk = {$urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom};
            rs = 2'($urandom);
            launch(rk, rs, $sformatf("rand%0d", n));
            wait_done($sformatf("rand%0d", n), 0);
            read_all($sformatf("rand%0d", n));
        end

        launch({K128A, 128'h0}, 2'd0, "ignore");
        repeat (5) @(posedge clk);
        @(negedge clk);
        key   = {K128B, 128'h0};
        sel   = 2'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignore", 6);
        read_all("ignore");

        launch({128'hffeeddccbbaa99887766554433221100, 128'h0}, 2'd0, "midrst");
        repeat (21) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst busy", 128'(busy), 128'(0));
        chk("midrst kv", 128'(key_valid), 128'(0));
        chk("midrst rk", round_key, 128'h0);
        model({K128B, 128'h0}, 2'd0);
        @(negedge clk);
        rst   = 1'b1;
        key   = {K128B, 128'h0};
        sel   = 2'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("postrst busy_on", 128'(busy), 128'(1));
        wait_done("postrst", 0);
        read_all("postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
